// File: rtl/fifo_buffer_param_if.sv
// FIFO access bundle: write/read requests, data, flush and status.
// Combinational only; it adds no latency.
// Backpressure is reported to the writer through full.
// Optional error signals are present when FIFO_ERR_FLAGS_EN is defined.
interface fifo_buffer_param_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 5
);
  logic                  write_data;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
  logic                  clear_errors;

  modport master (
    output write_data, data_in, read_data, flush, clear_errors,
    input  data_out, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
  modport slave (
    input  write_data, data_in, read_data, flush, clear_errors,
    output data_out, full, empty, almost_full, almost_empty, level,
           overflow, underflow
  );
`else
  modport master (
    output write_data, data_in, read_data, flush,
    input  data_out, full, empty, almost_full, almost_empty, level
  );
  modport slave (
    input  write_data, data_in, read_data, flush,
    output data_out, full, empty, almost_full, almost_empty, level
  );
`endif
endinterface

// File: rtl/fifo_buffer_param.sv
// Synchronous show-ahead FIFO, 2**ADDR_WIDTH words of DATA_WIDTH bits.
// Latency: a write is visible on data_out one cycle later; status flags are registered.
// Backpressure: writes on full are dropped unless a read is accepted in the same cycle.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_buffer_param #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_buffer_param_if.slave bus
);
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_ONE  = 1;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_AF   = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] LVL_AE   = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_af;
  logic                  r_ae;
  logic [ADDR_WIDTH:0]   w_level_nxt;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // A read on full frees the slot the concurrent write lands in.
  assign w_rd_acc = bus.read_data & ~r_empty;
  assign w_wr_acc = bus.write_data & (~r_full | w_rd_acc);

  // Next occupancy; flush overrides any accepted access.
  always_comb begin
    w_level_nxt = r_level;
    if (bus.flush) begin
      w_level_nxt = '0;
    end else if (w_wr_acc && !w_rd_acc) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_level_nxt = r_level - LVL_ONE;
    end
  end

  // Pointers, level and flags move together so status never lags the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == '0);
      r_af    <= (w_level_nxt >= LVL_AF);
      r_ae    <= (w_level_nxt <= LVL_AE);
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LVL_ONE;
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LVL_ONE;
      end
    end
  end

  // Storage array; contents survive reset and flush, only the pointers move.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.flush) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out     = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
  assign bus.level        = r_level;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.write_data && !w_wr_acc) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_errors) begin
        r_overflow <= 1'b0;
      end
      if (bus.read_data && r_empty) begin
        r_underflow <= 1'b1;
      end else if (bus.clear_errors) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_buffer_param.sv
// Directed bench for fifo_buffer_param plus a short reference-queue traffic run.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
// Error-flag checks are compiled in when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_buffer_param;
  localparam int DW    = 24;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [DW-1:0] q [$];

  fifo_buffer_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_buffer_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(28), .AE_THRESH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input int lvl);
    check_val({tag, ".level"}, 32'(bus.level), lvl);
    check_val({tag, ".full"},  32'(bus.full),  32'(lvl == DEPTH));
    check_val({tag, ".empty"}, 32'(bus.empty), 32'(lvl == 0));
    check_val({tag, ".af"},    32'(bus.almost_full),  32'(lvl >= 28));
    check_val({tag, ".ae"},    32'(bus.almost_empty), 32'(lvl <= 4));
  endtask

  task automatic push(input logic [DW-1:0] d);
    bus.write_data = 1'b1;
    bus.data_in    = d;
    tick();
    bus.write_data = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [DW-1:0] exp);
    check_val(tag, 32'(bus.data_out), 32'(exp));
    bus.read_data = 1'b1;
    tick();
    bus.read_data = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.write_data = 1'b0;
    bus.read_data  = 1'b0;
    bus.data_in    = '0;
    bus.flush      = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    bus.clear_errors = 1'b0;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_flags("reset", 0);
`ifdef FIFO_ERR_FLAGS_EN
    check_val("reset.ovf", 32'(bus.overflow), 0);
    check_val("reset.udf", 32'(bus.underflow), 0);
`endif
    #10 rst = 1'b0;
    tick();

    // Fill 0..31; flags tracked after every write.
    for (int i = 0; i < DEPTH; i++) begin
      push(DW'(i));
      check_flags($sformatf("fill%0d", i), i + 1);
    end

    // Drain in order, then two reads on empty.
    for (int i = 0; i < DEPTH; i++) begin
      pop($sformatf("drain%0d", i), DW'(i));
    end
    check_flags("drained", 0);
    bus.read_data = 1'b1;
    tick();
    tick();
    bus.read_data = 1'b0;
    check_flags("rd_empty", 0);
`ifdef FIFO_ERR_FLAGS_EN
    check_val("udf.set", 32'(bus.underflow), 1);
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    check_val("udf.clr", 32'(bus.underflow), 0);
`endif

    // Simultaneous read and write on full.
    for (int i = 0; i < DEPTH; i++) push(DW'(100 + i));
    check_flags("refill", DEPTH);
    bus.read_data  = 1'b1;
    bus.write_data = 1'b1;
    bus.data_in    = 24'hABCDEF;
    check_val("rw_full.head", 32'(bus.data_out), 100);
    tick();
    bus.read_data  = 1'b0;
    bus.write_data = 1'b0;
    check_flags("rw_full", DEPTH);
    for (int i = 1; i < DEPTH; i++) pop($sformatf("rw_drain%0d", i), DW'(100 + i));
    pop("rw_last", 24'hABCDEF);
    check_flags("rw_done", 0);

    // Write-only on full is dropped.
    for (int i = 0; i < DEPTH; i++) push(DW'(200 + i));
    push(24'h123456);
    check_flags("ovf", DEPTH);
`ifdef FIFO_ERR_FLAGS_EN
    check_val("ovf.set", 32'(bus.overflow), 1);
    bus.clear_errors = 1'b1;
    tick();
    bus.clear_errors = 1'b0;
    check_val("ovf.clr", 32'(bus.overflow), 0);
`endif
    for (int i = 0; i < DEPTH; i++) pop($sformatf("ovf_drain%0d", i), DW'(200 + i));
    check_flags("ovf_done", 0);

    // Flush beats a same-cycle write.
    for (int i = 0; i < 10; i++) push(DW'(300 + i));
    check_flags("pre_flush", 10);
    bus.flush      = 1'b1;
    bus.write_data = 1'b1;
    bus.data_in    = 24'h000777;
    tick();
    bus.flush      = 1'b0;
    bus.write_data = 1'b0;
    check_flags("flush", 0);
    push(24'h000055);
    check_flags("post_flush", 1);
    pop("post_flush.dout", 24'h000055);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) push(DW'(400 + i));
    check_flags("pre_rst", 5);
    #2 rst = 1'b1;
    #1;
    check_flags("mid_rst", 0);
    #4 rst = 1'b0;
    tick();
    push(24'h0000AA);
    check_val("post_rst.dout", 32'(bus.data_out), 32'h0000AA);
    check_flags("post_rst", 1);

    // Mixed traffic against a reference queue; pointers wrap past 64.
    q.delete();
    q.push_back(24'h0000AA);
    for (int k = 0; k < 100; k++) begin
      logic          wr;
      logic          rd;
      logic          racc;
      logic          wacc;
      logic [DW-1:0] d;
      wr = ($urandom_range(0, 99) < 75);
      rd = ($urandom_range(0, 99) < 65);
      d  = DW'($urandom);
      check_val($sformatf("rnd%0d.level", k), 32'(bus.level), q.size());
      check_val($sformatf("rnd%0d.full", k), 32'(bus.full), 32'(q.size() == DEPTH));
      if (q.size() > 0) check_val($sformatf("rnd%0d.dout", k), 32'(bus.data_out), 32'(q[0]));
      racc = rd && (q.size() > 0);
      wacc = wr && ((q.size() < DEPTH) || racc);
      bus.write_data = wr;
      bus.read_data  = rd;
      bus.data_in    = d;
      tick();
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
    end
    bus.write_data = 1'b0;
    bus.read_data  = 1'b0;
    check_val("rnd.final_level", 32'(bus.level), q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_buffer_param.md
FIFO_BUFFER_PARAM -- requirements
Module: fifo_buffer_param

Interface
REQ-001 Parameter DATA_WIDTH, default 24: width of each stored word in bits.
REQ-002 Parameter ADDR_WIDTH, default 5: depth is 2**ADDR_WIDTH entries (32 by default).
REQ-003 Parameter AF_THRESH, default 28: almost_full asserts when level >= AF_THRESH.
REQ-004 Parameter AE_THRESH, default 4: almost_empty asserts when level <= AE_THRESH.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 write_data  input  1  write request; data_in is pushed when accepted.
REQ-008 data_in  input  DATA_WIDTH  write word.
REQ-009 read_data  input  1  read request; pops the head entry when accepted.
REQ-010 data_out  output  DATA_WIDTH  head entry (show-ahead), valid whenever empty=0.
REQ-011 flush  input  1  synchronous clear of contents; it does not clear the error flags.
REQ-012 full / empty  output  1 each  level == 2**ADDR_WIDTH / level == 0.
REQ-013 almost_full / almost_empty  output  1 each  threshold flags per REQ-003/REQ-004.
REQ-014 level  output  ADDR_WIDTH+1  current number of stored entries, 0..2**ADDR_WIDTH.
REQ-015 overflow / underflow / clear_errors  output, output, input  1 each  present only per REQ-029.

Function
REQ-016 The block SHALL use read/write pointers of ADDR_WIDTH+1 bits, so that all 2**ADDR_WIDTH entries are usable; pointers wrap modulo 2**(ADDR_WIDTH+1).
REQ-017 A write SHALL be accepted when write_data=1 and (full=0 or an accepted read occurs in the same cycle).
REQ-018 A read SHALL be accepted when read_data=1 and empty=0; a read on empty is ignored and the pointer is unchanged.
REQ-019 Simultaneous accepted read and write SHALL leave level unchanged; on full both are accepted, and the freed slot takes data_in.
REQ-020 On empty with read_data=1 and write_data=1, only the write SHALL be accepted; level becomes 1.
REQ-021 data_out SHALL equal the entry at the read pointer combinationally; after a write into an empty FIFO, data_out is valid and empty=0 on the next cycle (1-cycle write-to-read latency).
REQ-022 level, full, empty, almost_full and almost_empty SHALL be registered and SHALL update in the same cycle as the pointer change.
REQ-023 flush=1 SHALL set both pointers and level to 0 on the next edge, and SHALL take priority over reads and writes in the same cycle.
REQ-024 Memory contents SHALL NOT be cleared by reset or flush; data_out is don't-care while empty=1.

Reset
REQ-025 While reset=1, the pointers and level SHALL be 0, with empty=1, almost_empty=1, full=0 and almost_full=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL discard all entries; the first write after release is read back first.
REQ-027 Any error flags SHALL reset to 0.

Configuration
REQ-028 Macro FIFO_ERR_FLAGS_EN SHALL control error reporting.
REQ-029 Defined: ports overflow, underflow and clear_errors exist. overflow sets sticky when a write is rejected on full. underflow sets sticky when a read is rejected on empty. clear_errors=1 clears both on the next edge; a set event in the same cycle wins.
REQ-030 Undefined: those three ports and their logic are absent; rejected accesses are silently ignored.

Verification
REQ-031 Reset, then write 0..31 on consecutive cycles -> full=1 and level=32 after the 32nd edge; almost_full first asserts after the 28th write.
REQ-032 Then read 32 cycles -> data_out is 0..31 in order; empty=1 and level=0 after the last pop; two further reads -> level stays 0, underflow=1 (when FIFO_ERR_FLAGS_EN is defined).
REQ-033 When full, read_data=1, write_data=1, data_in=0xABCDEF -> level stays 32; 0xABCDEF is read out as the 32nd word.
REQ-034 When full, write only, data_in=0x123456 -> write is ignored and overflow=1; clear_errors pulse -> overflow=0.
REQ-035 Write 10 words, flush together with write -> level=0 and empty=1 next cycle; the next written word is the first read.
REQ-036 Write 5 words, then reset for half a cycle mid-stream -> empty=1 immediately, level=0; run pointer-wrap traffic of 100 mixed operations against a reference queue model with no mismatch.
